ysyx_22040228_mcsr_trap: RTL and testbench
==========================================

Name: ysyx_22040228_mcsr_trap

Overview:
Parameterised next-generation machine-mode CSR file with an integrated trap controller. It holds the M-mode CSRs and mcycle/minstret counters. It samples software, timer, external and NUM_LIRQ platform interrupts, arbitrates them against synchronous exceptions and mret, and issues a one-cycle PC redirect to the fetch stage. It sits beside the EX/commit stage and replaces the fixed single-timer CSR unit.

Parameters:
XLEN, 64, data width of every CSR and datapath port
CNT_W, 64, implemented width of mcycle/minstret (1..XLEN); upper bits read 0
NUM_LIRQ, 4, platform interrupts (1..16), mapped to mip/mie bits 16..16+NUM_LIRQ-1

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
csr_rd_en  in  1  CSR read strobe
csr_wr_en  in  1  CSR write strobe (final value, set/clear already resolved)
csr_idx  in  12  CSR address
csr_wdata  in  XLEN  write data
csr_rdata  out  XLEN  read data (combinational)
csr_illegal  out  1  rd/wr to an unimplemented index (combinational)
commit_valid  in  1  instruction in commit slot is valid
commit_pc  in  XLEN  PC of that instruction
ex_stall  in  1  pipeline stalled; blocks writes, traps and minstret
exc_valid  in  1  synchronous exception on the commit instruction
exc_cause  in  XLEN  exception mcause code
exc_tval  in  XLEN  mtval value for the exception
mret_valid  in  1  commit instruction is mret
instret_inc  in  1  one instruction retired
msip_i  in  1  software interrupt
mtip_i  in  1  timer interrupt
meip_i  in  1  external interrupt
lirq_i  in  NUM_LIRQ  platform interrupts
irq_pending  out  1  enabled interrupt ready to be taken
redirect_valid  out  1  one-cycle fetch redirect
redirect_pc  out  XLEN  redirect target

Behaviour:
- Implemented CSRs: mstatus 0x300 (MIE[3], MPIE[7], MPP[12:11], FS[14:13], SD[63]), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344 (read-only, writes silently ignored), mcycle 0xB00, minstret 0xB02. Any other index with rd/wr asserted gives csr_illegal=1, csr_rdata=0, and no state change.
- Reset (async): all CSRs 0 except mstatus.MPP=2'b11. redirect_valid=0, redirect_pc=0, irq_pending=0.
- mip: msip/mtip/meip/lirq are registered into mip bits 3/7/11/16+ each cycle, giving 1-cycle latency.
- irq_pending = mstatus.MIE & |(mip & mie). It is combinational from registered state.
- Interrupt priority: MEI > MSI > MTI > lirq[0] > lirq[1] > ... Cause = bit index with XLEN-1 set.
- take = commit_valid & ~ex_stall & (exc_valid | irq_pending | mret_valid). Priority within take: exc > interrupt > mret.
- Trap update at the edge after take: mepc = commit_pc with bits [1:0] cleared; mcause = exc_cause or the interrupt cause; mtval = exc_tval for exceptions, 0 for interrupts; MPIE = MIE; MIE = 0; MPP = 2'b11.
- mret update: MIE = MPIE; MPIE = 1; MPP = 2'b00.
- Redirect timing: redirect_valid=1 for exactly the one cycle after take. redirect_pc is the trap target, or mepc for mret. Otherwise redirect_valid=0 and redirect_pc holds its last value.
- Trap target: {mtvec[XLEN-1:2],2'b00}. With vectored mode and an interrupt, the target is base + 4*cause_code.
- CSR write commits only when csr_wr_en & ~ex_stall & ~(commit_valid & (exc_valid | irq_pending)). A trap therefore suppresses the same-cycle write. A write to mstatus concurrent with mret is lost to mret.
- mepc write clears bits [1:0]. mstatus FS is writable; SD = (FS==2'b11).
- mcycle increments every cycle, including stalls. A write loads csr_wdata[CNT_W-1:0], with no increment in that cycle.
- minstret increments when instret_inc & ~ex_stall. A write has priority over increment.
- Both counters wrap at 2^CNT_W - 1 -> 0.
- Reset asserted mid-trap: redirect_valid is cleared immediately (async); no partial CSR update survives.

Optional Feature:
YSYX_22040228_CSR_VECTOR_EN:
- Defined: mtvec[1:0] is writable, values 00 or 01. Any write of 1x stores 00. Mode 01 gives vectored interrupt targets; exceptions always go to base.
- Undefined: mtvec[1:0] is hardwired 00, writes to those bits are ignored, and all traps go to base.

Test Plan:
- Reset then read 0x300 -> csr_rdata=0x1800. Read 0x7C0 -> csr_illegal=1, csr_rdata=0.
- Write mtvec=0x8000_0001 (VECTOR_EN), mie=0x80, mstatus=0x8. Pulse mtip_i, commit_valid, commit_pc=0x8000_1002 -> redirect_valid one cycle later with redirect_pc=0x8000_001C. mepc=0x8000_1000, mcause=0x8000_0000_0000_0007, mstatus=0x1880.
- Follow with mret_valid -> redirect_pc=0x8000_1000, mstatus=0x88.
- exc_valid cause 11 together with csr_wr_en to mscratch=0x55 and a pending enabled MEI -> mcause=11, mscratch unchanged, redirect_pc=base.
- CNT_W=8: write mcycle=0xFE -> reads 0xFE, then 0xFF, then 0x00. Hold ex_stall with instret_inc=1 -> minstret unchanged.
- NUM_LIRQ=4: enable lirq[1] and lirq[3], assert both -> mcause=0x8000_0000_0000_0011. Assert rst during the redirect cycle -> redirect_valid drops without waiting for clk.

Source files
------------

// File: rtl/ysyx_22040228_mcsr_trap.sv
// Machine-mode CSR file with trap/interrupt arbitration and a one-cycle fetch redirect.
// Optional macro YSYX_22040228_CSR_VECTOR_EN enables vectored interrupt targets via mtvec[1:0].
module ysyx_22040228_mcsr_trap #(
  parameter int XLEN     = 64,
  parameter int CNT_W    = 64,
  parameter int NUM_LIRQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                csr_rd_en,
  input  logic                csr_wr_en,
  input  logic [11:0]         csr_idx,
  input  logic [XLEN-1:0]     csr_wdata,
  output logic [XLEN-1:0]     csr_rdata,
  output logic                csr_illegal,
  input  logic                commit_valid,
  input  logic [XLEN-1:0]     commit_pc,
  input  logic                ex_stall,
  input  logic                exc_valid,
  input  logic [XLEN-1:0]     exc_cause,
  input  logic [XLEN-1:0]     exc_tval,
  input  logic                mret_valid,
  input  logic                instret_inc,
  input  logic                msip_i,
  input  logic                mtip_i,
  input  logic                meip_i,
  input  logic [NUM_LIRQ-1:0] lirq_i,
  output logic                irq_pending,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;

  logic            st_mie, st_mpie;
  logic [1:0]      st_mpp, st_fs;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q;
  logic [CNT_W-1:0] mcycle_q, minstret_q;

  logic [XLEN-1:0] mstatus_val, rdata_mux, mip_d, pend_vec, irq_cause;
  logic [XLEN-1:0] mtvec_wr, trap_base, trap_target;
  logic [4:0]      irq_code;
  logic            csr_hit, take, trap_exc, trap_irq, do_mret, wr_ok;

  always_comb begin
    mstatus_val          = '0;
    mstatus_val[3]       = st_mie;
    mstatus_val[7]       = st_mpie;
    mstatus_val[12:11]   = st_mpp;
    mstatus_val[14:13]   = st_fs;
    mstatus_val[XLEN-1]  = (st_fs == 2'b11);
  end

  always_comb begin
    csr_hit   = 1'b1;
    rdata_mux = '0;
    case (csr_idx)
      A_MSTATUS:  rdata_mux = mstatus_val;
      A_MIE:      rdata_mux = mie_q;
      A_MTVEC:    rdata_mux = mtvec_q;
      A_MSCRATCH: rdata_mux = mscratch_q;
      A_MEPC:     rdata_mux = mepc_q;
      A_MCAUSE:   rdata_mux = mcause_q;
      A_MTVAL:    rdata_mux = mtval_q;
      A_MIP:      rdata_mux = mip_q;
      A_MCYCLE:   rdata_mux = XLEN'(mcycle_q);
      A_MINSTRET: rdata_mux = XLEN'(minstret_q);
      default:    csr_hit   = 1'b0;
    endcase
  end

  assign csr_rdata   = rdata_mux;
  assign csr_illegal = (csr_rd_en | csr_wr_en) & ~csr_hit;

  always_comb begin
    mip_d                  = '0;
    mip_d[3]               = msip_i;
    mip_d[7]               = mtip_i;
    mip_d[11]              = meip_i;
    mip_d[16 +: NUM_LIRQ]  = lirq_i;
  end

  assign pend_vec    = mip_q & mie_q;
  assign irq_pending = st_mie & (|pend_vec);

  // Scan from lowest to highest priority so the last match wins.
  always_comb begin
    irq_code = 5'd0;
    for (int i = NUM_LIRQ - 1; i >= 0; i--)
      if (pend_vec[16+i]) irq_code = 5'(16 + i);
    if (pend_vec[7])  irq_code = 5'd7;
    if (pend_vec[3])  irq_code = 5'd3;
    if (pend_vec[11]) irq_code = 5'd11;
    irq_cause         = XLEN'(irq_code);
    irq_cause[XLEN-1] = 1'b1;
  end

  assign take     = commit_valid & ~ex_stall & (exc_valid | irq_pending | mret_valid);
  assign trap_exc = take & exc_valid;
  assign trap_irq = take & ~exc_valid & irq_pending;
  assign do_mret  = take & ~exc_valid & ~irq_pending & mret_valid;
  assign wr_ok    = csr_wr_en & ~ex_stall & ~(commit_valid & (exc_valid | irq_pending));

  assign trap_base = mtvec_q & ~XLEN'(3);

`ifdef YSYX_22040228_CSR_VECTOR_EN
  assign mtvec_wr    = {csr_wdata[XLEN-1:2], csr_wdata[1] ? 2'b00 : csr_wdata[1:0]};
  assign trap_target = (trap_irq && mtvec_q[1:0] == 2'b01) ?
                       trap_base + (XLEN'(irq_code) << 2) : trap_base;
`else
  assign mtvec_wr    = csr_wdata & ~XLEN'(3);
  assign trap_target = trap_base;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie         <= 1'b0;
      st_mpie        <= 1'b0;
      st_mpp         <= 2'b11;
      st_fs          <= 2'b00;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mip_q          <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      mip_q <= mip_d;
      if (wr_ok) begin
        case (csr_idx)
          A_MSTATUS: begin
            st_mie  <= csr_wdata[3];
            st_mpie <= csr_wdata[7];
            st_mpp  <= csr_wdata[12:11];
            st_fs   <= csr_wdata[14:13];
          end
          A_MIE:      mie_q      <= csr_wdata;
          A_MTVEC:    mtvec_q    <= mtvec_wr;
          A_MSCRATCH: mscratch_q <= csr_wdata;
          A_MEPC:     mepc_q     <= csr_wdata & ~XLEN'(3);
          A_MCAUSE:   mcause_q   <= csr_wdata;
          A_MTVAL:    mtval_q    <= csr_wdata;
          default: ;
        endcase
      end
      // Trap/mret updates come last so they override a concurrent mstatus write.
      if (trap_exc | trap_irq) begin
        mepc_q   <= commit_pc & ~XLEN'(3);
        mcause_q <= trap_exc ? exc_cause : irq_cause;
        mtval_q  <= trap_exc ? exc_tval : '0;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
        st_mpp   <= 2'b11;
      end else if (do_mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
        st_mpp  <= 2'b00;
      end
      redirect_valid <= take;
      if (take) redirect_pc <= do_mret ? mepc_q : trap_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (wr_ok && csr_idx == A_MCYCLE) mcycle_q <= csr_wdata[CNT_W-1:0];
      else                              mcycle_q <= mcycle_q + CNT_W'(1);
      if (wr_ok && csr_idx == A_MINSTRET)   minstret_q <= csr_wdata[CNT_W-1:0];
      else if (instret_inc && !ex_stall)    minstret_q <= minstret_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_22040228_mcsr_trap.sv
// Bench for ysyx_22040228_mcsr_trap: directed scenarios, then random traffic against a reference model.
module tb_ysyx_22040228_mcsr_trap;
  localparam int XLEN = 64;
  localparam int CNT_W = 8;
  localparam int NL = 4;
`ifdef YSYX_22040228_CSR_VECTOR_EN
  localparam bit VEC_EN = 1'b1;
`else
  localparam bit VEC_EN = 1'b0;
`endif

  logic clk, rst;
  logic csr_rd_en, csr_wr_en;
  logic [11:0] csr_idx;
  logic [63:0] csr_wdata, csr_rdata;
  logic csr_illegal, commit_valid, ex_stall, exc_valid, mret_valid, instret_inc;
  logic [63:0] commit_pc, exc_cause, exc_tval, redirect_pc;
  logic msip_i, mtip_i, meip_i, irq_pending, redirect_valid;
  logic [NL-1:0] lirq_i;

  ysyx_22040228_mcsr_trap #(.XLEN(XLEN), .CNT_W(CNT_W), .NUM_LIRQ(NL)) dut (
    .clk(clk), .rst(rst), .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en),
    .csr_idx(csr_idx), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .ex_stall(ex_stall), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_tval(exc_tval), .mret_valid(mret_valid), .instret_inc(instret_inc),
    .msip_i(msip_i), .mtip_i(mtip_i), .meip_i(meip_i), .lirq_i(lirq_i),
    .irq_pending(irq_pending), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_csr(input logic [11:0] a, input logic [63:0] d);
    csr_wr_en = 1'b1; csr_idx = a; csr_wdata = d;
    cyc();
    csr_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [63:0] exp, input string tag);
    csr_rd_en = 1'b1; csr_idx = a;
    #1;
    chk(tag, csr_rdata, exp);
    csr_rd_en = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic        m_mie_b, m_mpie;
  logic [1:0]  m_mpp, m_fs;
  logic [63:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip, m_rpc;
  int unsigned m_cyc, m_ins;
  logic        m_rv;

  logic [11:0] legal_idx [10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02};
  logic [11:0] idx_pool [12]  = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02,
                                  12'h7C0, 12'h301};
  int irq_order [3+NL] = '{11, 3, 7, 16, 17, 18, 19};

  task automatic m_reset();
    m_mie_b = 0; m_mpie = 0; m_mpp = 2'b11; m_fs = 0;
    m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_mip = 0; m_cyc = 0; m_ins = 0; m_rv = 0; m_rpc = 0;
  endtask

  function automatic logic [63:0] m_mstatus();
    logic [63:0] v;
    v = (64'(m_mie_b) << 3) | (64'(m_mpie) << 7) | (64'(m_mpp) << 11) | (64'(m_fs) << 13);
    if (m_fs == 2'b11) v = v | 64'h8000_0000_0000_0000;
    return v;
  endfunction

  function automatic bit m_legal(input logic [11:0] a);
    foreach (legal_idx[i]) if (legal_idx[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus();
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip;
      12'hB00: return 64'(m_cyc);
      12'hB02: return 64'(m_ins);
      default: return 64'd0;
    endcase
  endfunction

  function automatic int m_irq_code();
    foreach (irq_order[i])
      if (m_mip[irq_order[i]] && m_mie[irq_order[i]]) return irq_order[i];
    return -1;
  endfunction

  function automatic bit m_pend();
    return m_mie_b && (m_irq_code() >= 0);
  endfunction

  task automatic m_step();
    bit pend, take, wok;
    int code;
    logic old_mie, old_mpie;
    logic [63:0] old_mepc, base, lo;
    pend = m_pend(); code = m_irq_code();
    old_mie = m_mie_b; old_mpie = m_mpie; old_mepc = m_mepc;
    base = m_mtvec & ~64'd3;
    take = commit_valid && !ex_stall && (exc_valid || pend || mret_valid);
    wok  = csr_wr_en && !ex_stall && !(commit_valid && (exc_valid || pend));
    if (wok) begin
      case (csr_idx)
        12'h300: begin m_mie_b = csr_wdata[3]; m_mpie = csr_wdata[7];
                       m_mpp = csr_wdata[12:11]; m_fs = csr_wdata[14:13]; end
        12'h304: m_mie = csr_wdata;
        12'h305: begin
          lo = (VEC_EN && csr_wdata[1:0] == 2'b01) ? 64'd1 : 64'd0;
          m_mtvec = (csr_wdata & ~64'd3) | lo;
        end
        12'h340: m_mscratch = csr_wdata;
        12'h341: m_mepc = csr_wdata & ~64'd3;
        12'h342: m_mcause = csr_wdata;
        12'h343: m_mtval = csr_wdata;
        default: ;
      endcase
    end
    if (wok && csr_idx == 12'hB00) m_cyc = csr_wdata[7:0];
    else m_cyc = (m_cyc + 1) % 256;
    if (wok && csr_idx == 12'hB02) m_ins = csr_wdata[7:0];
    else if (instret_inc && !ex_stall) m_ins = (m_ins + 1) % 256;
    m_rv = take;
    if (take) begin
      if (exc_valid || pend) begin
        m_mepc = commit_pc & ~64'd3;
        m_mpie = old_mie; m_mie_b = 0; m_mpp = 2'b11;
        if (exc_valid) begin
          m_mcause = exc_cause; m_mtval = exc_tval; m_rpc = base;
        end else begin
          m_mcause = 64'h8000_0000_0000_0000 | 64'(code); m_mtval = 0;
          m_rpc = (VEC_EN && m_mtvec[1:0] == 2'b01) ? base + 64'(4 * code) : base;
        end
      end else begin
        m_mie_b = old_mpie; m_mpie = 1; m_mpp = 2'b00; m_rpc = old_mepc;
      end
    end
    m_mip = 0;
    m_mip[3] = msip_i; m_mip[7] = mtip_i; m_mip[11] = meip_i;
    for (int i = 0; i < NL; i++) m_mip[16+i] = lirq_i[i];
  endtask

  initial begin
    logic [63:0] exp_tgt;
    rst = 1; csr_rd_en = 0; csr_wr_en = 0; csr_idx = 0; csr_wdata = 0;
    commit_valid = 0; commit_pc = 0; ex_stall = 0; exc_valid = 0; exc_cause = 0;
    exc_tval = 0; mret_valid = 0; instret_inc = 0; msip_i = 0; mtip_i = 0;
    meip_i = 0; lirq_i = 0;
    repeat (2) cyc();
    rst = 0;

    // reset state
    chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("rst_redirect_pc", redirect_pc, 64'd0);
    chk("rst_irq_pending", 64'(irq_pending), 64'd0);
    rd(12'h300, 64'h1800, "rst_mstatus");
    csr_rd_en = 1; csr_idx = 12'h7C0; #1;
    chk("illegal_flag", 64'(csr_illegal), 64'd1);
    chk("illegal_rdata", csr_rdata, 64'd0);
    csr_rd_en = 0;

    // timer interrupt into a vectored/direct mtvec
    wr_csr(12'h305, 64'h8000_0001);
    wr_csr(12'h304, 64'h80);
    wr_csr(12'h300, 64'h8);
    rd(12'h305, VEC_EN ? 64'h8000_0001 : 64'h8000_0000, "mtvec_rb");
    mtip_i = 1; cyc(); mtip_i = 0;
    chk("mti_pending", 64'(irq_pending), 64'd1);
    commit_valid = 1; commit_pc = 64'h8000_1002; cyc(); commit_valid = 0;
    chk("mti_redirect_valid", 64'(redirect_valid), 64'd1);
    chk("mti_redirect_pc", redirect_pc, VEC_EN ? 64'h8000_001C : 64'h8000_0000);
    rd(12'h341, 64'h8000_1000, "mti_mepc");
    rd(12'h342, 64'h8000_0000_0000_0007, "mti_mcause");
    rd(12'h300, 64'h1880, "mti_mstatus");
    rd(12'h343, 64'd0, "mti_mtval");
    exp_tgt = redirect_pc;
    cyc();
    chk("redirect_one_cycle", 64'(redirect_valid), 64'd0);
    chk("redirect_pc_hold", redirect_pc, VEC_EN ? 64'h8000_001C : 64'h8000_0000);

    // mret
    commit_valid = 1; mret_valid = 1; cyc(); commit_valid = 0; mret_valid = 0;
    chk("mret_redirect_valid", 64'(redirect_valid), 64'd1);
    chk("mret_redirect_pc", redirect_pc, 64'h8000_1000);
    rd(12'h300, 64'h88, "mret_mstatus");

    // exception beats pending MEI and suppresses the CSR write
    wr_csr(12'h304, 64'h880);
    meip_i = 1; cyc();
    chk("mei_pending", 64'(irq_pending), 64'd1);
    commit_valid = 1; commit_pc = 64'h8000_2000; exc_valid = 1; exc_cause = 64'd11;
    exc_tval = 64'h1234; csr_wr_en = 1; csr_idx = 12'h340; csr_wdata = 64'h55;
    cyc();
    commit_valid = 0; exc_valid = 0; csr_wr_en = 0; meip_i = 0;
    chk("exc_redirect_pc", redirect_pc, 64'h8000_0000);
    rd(12'h342, 64'd11, "exc_mcause");
    rd(12'h340, 64'd0, "exc_mscratch_kept");
    rd(12'h343, 64'h1234, "exc_mtval");
    rd(12'h341, 64'h8000_2000, "exc_mepc");
    cyc();

    // 8-bit counters
    wr_csr(12'hB00, 64'hFE);
    rd(12'hB00, 64'hFE, "mcycle_load");
    cyc(); rd(12'hB00, 64'hFF, "mcycle_ff");
    cyc(); rd(12'hB00, 64'h00, "mcycle_wrap");
    rd(12'hB02, 64'd0, "minstret_init");
    ex_stall = 1; instret_inc = 1; repeat (3) cyc();
    rd(12'hB02, 64'd0, "minstret_stalled");
    ex_stall = 0; repeat (2) cyc(); instret_inc = 0;
    rd(12'hB02, 64'd2, "minstret_count");

    // platform interrupts, then async reset during the redirect cycle
    wr_csr(12'h300, 64'h8);
    wr_csr(12'h304, 64'h000A_0000);
    lirq_i = 4'b1010; cyc();
    chk("lirq_pending", 64'(irq_pending), 64'd1);
    commit_valid = 1; commit_pc = 64'h8000_3000; cyc(); commit_valid = 0; lirq_i = 0;
    chk("lirq_redirect_valid", 64'(redirect_valid), 64'd1);
    chk("lirq_redirect_pc", redirect_pc, VEC_EN ? 64'h8000_0044 : 64'h8000_0000);
    rd(12'h342, 64'h8000_0000_0000_0011, "lirq_mcause");
    #1 rst = 1;
    #1;
    chk("async_rst_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("async_rst_redirect_pc", redirect_pc, 64'd0);
    rd(12'h300, 64'h1800, "async_rst_mstatus");
    rd(12'h342, 64'd0, "async_rst_mcause");
    cyc(); cyc();
    rst = 0;
    m_reset();

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      ex_stall     = ($urandom % 4) == 0;
      commit_valid = $urandom % 2;
      exc_valid    = ($urandom % 8) == 0;
      mret_valid   = ($urandom % 8) == 0;
      exc_cause    = {32'd0, 32'($urandom % 16)};
      exc_tval     = {$urandom, $urandom};
      commit_pc    = {$urandom, $urandom};
      instret_inc  = $urandom % 2;
      csr_rd_en    = $urandom % 2;
      csr_wr_en    = ($urandom % 3) == 0;
      csr_idx      = idx_pool[$urandom % 12];
      csr_wdata    = {$urandom, $urandom};
      msip_i       = ($urandom % 4) == 0;
      mtip_i       = ($urandom % 4) == 0;
      meip_i       = ($urandom % 4) == 0;
      lirq_i       = NL'($urandom);
      #1;
      if (csr_rd_en) chk("rnd_rdata", csr_rdata, m_read(csr_idx));
      chk("rnd_illegal", 64'(csr_illegal), 64'((csr_rd_en | csr_wr_en) & !m_legal(csr_idx)));
      chk("rnd_irq_pending", 64'(irq_pending), 64'(m_pend()));
      m_step();
      cyc();
      chk("rnd_redirect_valid", 64'(redirect_valid), 64'(m_rv));
      chk("rnd_redirect_pc", redirect_pc, m_rpc);
    end
    csr_rd_en = 0; csr_wr_en = 0; commit_valid = 0;
    foreach (legal_idx[i]) rd(legal_idx[i], m_read(legal_idx[i]), "final_csr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
